stopwatch_digit_counter: RTL and testbench

- Parametrised single-digit stopwatch counter: one instance per display digit, cascaded via tick_in/carry_out to form seconds/minutes chains (mod 10 units, mod 6 tens).
- Replaces hard-wired two-flip-flop per-digit counters. Adds:
  - generic modulus
  - up/down direction
  - run/hold state machine
  - synchronous clear and preset load
  - ripple-carry/borrow
  - integrated 7-segment decode with ripple leading-zero blanking

---
 rtl/stopwatch_digit_counter.sv | 188 ++++++++++++++++++
 tb/tb_stopwatch_digit_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_digit_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_digit_counter
//
// One display digit of a stopwatch. Instances are chained through
// tick_in/carry_out so a units/tens chain resolves within a single clock
// (mod 10 for units, mod 6 for tens of seconds/minutes).
//
// State table:
//   state | meaning
//   HOLD  | digit frozen; ticks ignored, carry_out held low
//   RUN   | digit advances on every tick_in, carry_out flags the wrap
//
// Parameters:
//   MODULUS        count range 0..MODULUS-1, legal 2..16
//   PRESET         value taken on reset and on clr, must be < MODULUS
//   SEG_ACTIVE_LOW 1 inverts all segment drives (common-anode displays)
//
// Ports:
//   CLK_IN    system clock, all state changes on the rising edge
//   RST       asynchronous active-high reset
//   start     enter RUN (level-sampled)
//   stop      enter HOLD (level-sampled, wins over start)
//   clr       synchronous return of digit to PRESET
//   load      synchronous load of load_val (saturated to MODULUS-1)
//   load_val  value used by load
//   dir       0 = count up, 1 = count down
//   tick_in   count enable (1 Hz strobe or carry_out of the previous digit)
//   blank     force all segments off
//   rbi       ripple-blank in: blank this digit if it reads zero
//   digit     current count, binary (registered)
//   seg       {a,b,c,d,e,f,g} segment drives (combinational)
//   carry_out wrap/borrow strobe to the next digit (combinational)
//   rbo       ripple-blank out (combinational)
//   running   1 while in RUN (registered)
// -----------------------------------------------------------------------------
module stopwatch_digit_counter #(
    parameter int MODULUS        = 10,
    parameter int PRESET         = 0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dir,
    input  logic       tick_in,
    input  logic       blank,
    input  logic       rbi,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       carry_out,
    output logic       rbo,
    output logic       running
);

    // Reject illegal parameterisations at elaboration.
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
        $error("stopwatch_digit_counter: MODULUS must be in 2..16");
    end
    if (PRESET < 0 || PRESET >= MODULUS) begin : g_bad_preset
        $error("stopwatch_digit_counter: PRESET must be in 0..MODULUS-1");
    end

    localparam logic [3:0] MAX_VAL    = 4'(MODULUS - 1);
    localparam logic [3:0] PRESET_VAL = 4'(PRESET);
    // Five bits so MODULUS = 16 still compares correctly against load_val.
    localparam logic [4:0] MOD_VAL    = 5'(MODULUS);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] load_sat;
    logic [3:0] count_next;
    logic       terminal;
    logic       advance;
    logic       is_zero;
    logic       seg_off;
    logic [6:0] glyph;
    logic [6:0] seg_hi;

    // ------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------
    always_comb begin
        load_sat = load_val;
        if ({1'b0, load_val} >= MOD_VAL) begin
            load_sat = MAX_VAL;
        end
    end

    assign is_zero  = (digit == 4'd0);
    assign terminal = dir ? is_zero : (digit == MAX_VAL);

    always_comb begin
        count_next = digit;
        if (dir) begin
            count_next = is_zero ? MAX_VAL : (digit - 4'd1);
        end else begin
            count_next = (digit == MAX_VAL) ? 4'd0 : (digit + 4'd1);
        end
    end

    // Counting uses the state held before the edge, so the cycle in which
    // start is sampled never advances the digit.
    assign advance = (state == RUN) && tick_in;

    // ------------------------------------------------------------------
    // Run/hold state machine and digit register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state   <= HOLD;
            running <= 1'b0;
            digit   <= PRESET_VAL;
        end else begin
            case (state)
                HOLD: begin
                    if (start && !stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= HOLD;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= HOLD;
                    running <= 1'b0;
                end
            endcase

            if (clr) begin
                digit <= PRESET_VAL;
            end else if (load) begin
                digit <= load_sat;
            end else if (advance) begin
                digit <= count_next;
            end
        end
    end

    // Combinational so a whole cascade ripples within one cycle. clr and
    // load suppress it because they override the count on that edge.
    assign carry_out = running & tick_in & ~clr & ~load & terminal;

    // ------------------------------------------------------------------
    // 7-segment decode, {a,b,c,d,e,f,g}, active-high before polarity
    // ------------------------------------------------------------------
    always_comb begin
        glyph = 7'b0000000;
        case (digit)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            4'hF: glyph = 7'b1000111;
            default: glyph = 7'b0000000;
        endcase
    end

    // Leading-zero blanking ripples from the most significant digit down:
    // a zero digit stays dark only while every digit above it is dark.
    assign rbo     = rbi & is_zero;
    assign seg_off = blank | (rbi & is_zero);
    assign seg_hi  = seg_off ? 7'b0000000 : glyph;
    assign seg     = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: tb/tb_stopwatch_digit_counter.sv
module tb_stopwatch_digit_counter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Group A: mod 10 digit, plus an active-low twin sharing its inputs
    logic       a_start, a_stop, a_clr, a_load, a_dir, a_tick, a_blank, a_rbi;
    logic [3:0] a_lv;
    logic [3:0] a_digit, l_digit;
    logic [6:0] a_seg, l_seg;
    logic       a_carry, a_rbo, a_run, l_carry, l_rbo, l_run;

    // Group B: mod 6 digit
    logic       b_start, b_stop, b_clr, b_load, b_dir, b_tick, b_blank, b_rbi;
    logic [3:0] b_lv;
    logic [3:0] b_digit;
    logic [6:0] b_seg;
    logic       b_carry, b_rbo, b_run;

    // Group C: units (mod 10) cascaded into tens (mod 6)
    logic       c_start, c_stop, c_clr, c_load, c_dir, c_tick, c_blank, c_rbi;
    logic [3:0] c_lv;
    logic [3:0] cu_digit, ct_digit;
    logic [6:0] cu_seg, ct_seg;
    logic       cu_carry, cu_rbo, cu_run, ct_carry, ct_rbo, ct_run;

    stopwatch_digit_counter #(.MODULUS(10), .PRESET(0), .SEG_ACTIVE_LOW(1'b0)) ua (
        .CLK_IN(clk), .RST(rst), .start(a_start), .stop(a_stop), .clr(a_clr),
        .load(a_load), .load_val(a_lv), .dir(a_dir), .tick_in(a_tick),
        .blank(a_blank), .rbi(a_rbi), .digit(a_digit), .seg(a_seg),
        .carry_out(a_carry), .rbo(a_rbo), .running(a_run));

    stopwatch_digit_counter #(.MODULUS(10), .PRESET(0), .SEG_ACTIVE_LOW(1'b1)) ul (
        .CLK_IN(clk), .RST(rst), .start(a_start), .stop(a_stop), .clr(a_clr),
        .load(a_load), .load_val(a_lv), .dir(a_dir), .tick_in(a_tick),
        .blank(a_blank), .rbi(a_rbi), .digit(l_digit), .seg(l_seg),
        .carry_out(l_carry), .rbo(l_rbo), .running(l_run));

    stopwatch_digit_counter #(.MODULUS(6), .PRESET(0), .SEG_ACTIVE_LOW(1'b0)) ub (
        .CLK_IN(clk), .RST(rst), .start(b_start), .stop(b_stop), .clr(b_clr),
        .load(b_load), .load_val(b_lv), .dir(b_dir), .tick_in(b_tick),
        .blank(b_blank), .rbi(b_rbi), .digit(b_digit), .seg(b_seg),
        .carry_out(b_carry), .rbo(b_rbo), .running(b_run));

    stopwatch_digit_counter #(.MODULUS(10), .PRESET(0), .SEG_ACTIVE_LOW(1'b0)) cu (
        .CLK_IN(clk), .RST(rst), .start(c_start), .stop(c_stop), .clr(c_clr),
        .load(c_load), .load_val(c_lv), .dir(c_dir), .tick_in(c_tick),
        .blank(c_blank), .rbi(c_rbi), .digit(cu_digit), .seg(cu_seg),
        .carry_out(cu_carry), .rbo(cu_rbo), .running(cu_run));

    stopwatch_digit_counter #(.MODULUS(6), .PRESET(0), .SEG_ACTIVE_LOW(1'b0)) ct (
        .CLK_IN(clk), .RST(rst), .start(c_start), .stop(c_stop), .clr(c_clr),
        .load(c_load), .load_val(c_lv), .dir(c_dir), .tick_in(cu_carry),
        .blank(c_blank), .rbi(c_rbi), .digit(ct_digit), .seg(ct_seg),
        .carry_out(ct_carry), .rbo(ct_rbo), .running(ct_run));

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    int u_exp, t_exp, b_exp, pulses;

    initial begin
        rst = 1'b1;
        {a_start, a_stop, a_clr, a_load, a_dir, a_tick, a_blank, a_rbi} = '0;
        {b_start, b_stop, b_clr, b_load, b_dir, b_tick, b_blank, b_rbi} = '0;
        {c_start, c_stop, c_clr, c_load, c_dir, c_tick, c_blank, c_rbi} = '0;
        a_lv = 4'd0; b_lv = 4'd0; c_lv = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        // Reset state of every instance
        chk("rst_a_digit", 16'(a_digit), 16'd0);
        chk("rst_a_run",   16'(a_run),   16'd0);
        chk("rst_a_seg",   16'(a_seg),   16'h7E);
        chk("rst_a_carry", 16'(a_carry), 16'd0);
        chk("rst_a_rbo",   16'(a_rbo),   16'd0);
        chk("rst_l_digit", 16'(l_digit), 16'd0);
        chk("rst_l_seg",   16'(l_seg),   16'h01);
        chk("rst_l_misc",  16'({l_carry, l_rbo, l_run}), 16'd0);
        chk("rst_b_digit", 16'(b_digit), 16'd0);
        chk("rst_b_seg",   16'(b_seg),   16'h7E);
        chk("rst_b_misc",  16'({b_carry, b_rbo, b_run}), 16'd0);
        chk("rst_c_digits", 16'({ct_digit, cu_digit}), 16'h00);
        chk("rst_c_segs",  16'({ct_seg, cu_seg}), 16'({7'h7E, 7'h7E}));
        chk("rst_c_misc",  16'({cu_carry, cu_rbo, cu_run, ct_carry, ct_rbo, ct_run}), 16'd0);

        // Ticks without start: digit stays put
        a_tick = 1'b1;
        rst = 1'b0;
        #1;
        chk("hold_carry", 16'(a_carry), 16'd0);
        repeat (3) begin
            edge1();
            chk("hold_digit", 16'(a_digit), 16'd0);
            chk("hold_run",   16'(a_run),   16'd0);
        end

        // Group A: count down from 0 with borrow, then start+stop together
        a_dir = 1'b1;
        a_start = 1'b1;
        edge1();
        a_start = 1'b0;
        chk("dn_run",   16'(a_run),   16'd1);
        chk("dn_start_nocount", 16'(a_digit), 16'd0);
        #1;
        chk("dn_borrow", 16'(a_carry), 16'd1);
        edge1();
        chk("dn_d9", 16'(a_digit), 16'd9);
        #1;
        chk("dn_d9_carry", 16'(a_carry), 16'd0);
        edge1();
        chk("dn_d8", 16'(a_digit), 16'd8);
        edge1();
        chk("dn_d7", 16'(a_digit), 16'd7);
        a_start = 1'b1;
        a_stop  = 1'b1;
        edge1();
        chk("ss_run",   16'(a_run),   16'd0);
        chk("ss_digit", 16'(a_digit), 16'd6);
        a_start = 1'b0;
        a_stop  = 1'b0;
        edge1();
        chk("ss_frozen", 16'(a_digit), 16'd6);
        chk("ss_l_digit", 16'(l_digit), 16'd6);
        #1;
        chk("ss_carry", 16'(a_carry), 16'd0);

        // Group A: blanking, glyphs and active-low polarity
        a_tick = 1'b0;
        a_clr = 1'b1;
        edge1();
        a_clr = 1'b0;
        chk("clr_digit", 16'(a_digit), 16'd0);
        a_rbi = 1'b1;
        #1;
        chk("rb0_seg",   16'(a_seg), 16'h00);
        chk("rb0_rbo",   16'(a_rbo), 16'd1);
        chk("rb0_l_seg", 16'(l_seg), 16'h7F);
        a_load = 1'b1;
        a_lv = 4'd3;
        edge1();
        a_load = 1'b0;
        #1;
        chk("rb3_digit", 16'(a_digit), 16'd3);
        chk("rb3_seg",   16'(a_seg),   16'h79);
        chk("rb3_rbo",   16'(a_rbo),   16'd0);
        chk("rb3_l_seg", 16'(l_seg),   16'h06);
        a_blank = 1'b1;
        #1;
        chk("blank_seg",   16'(a_seg), 16'h00);
        chk("blank_l_seg", 16'(l_seg), 16'h7F);
        a_blank = 1'b0;
        a_rbi = 1'b0;
        a_load = 1'b1;
        a_lv = 4'd15;
        edge1();
        a_load = 1'b0;
        #1;
        chk("sat10_digit", 16'(a_digit), 16'd9);
        chk("sat10_seg",   16'(a_seg),   16'h7B);

        // Group B: mod 6 up-count with carry at 5
        b_tick = 1'b1;
        b_start = 1'b1;
        edge1();
        b_start = 1'b0;
        chk("m6_run",   16'(b_run),   16'd1);
        chk("m6_start", 16'(b_digit), 16'd0);
        b_exp = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("m6_carry", 16'(b_carry), (b_exp == 5) ? 16'd1 : 16'd0);
            edge1();
            b_exp = (b_exp + 1) % 6;
            chk("m6_digit", 16'(b_digit), 16'(b_exp));
        end
        // Load saturation, carry suppression by load, clr beats load
        b_load = 1'b1;
        b_lv = 4'd12;
        edge1();
        chk("m6_sat", 16'(b_digit), 16'd5);
        #1;
        chk("m6_load_nocarry", 16'(b_carry), 16'd0);
        edge1();
        chk("m6_load_hold", 16'(b_digit), 16'd5);
        b_clr = 1'b1;
        b_lv = 4'd4;
        edge1();
        chk("m6_clr_wins", 16'(b_digit), 16'd0);
        b_clr = 1'b0;
        b_load = 1'b0;
        b_stop = 1'b1;
        edge1();
        chk("m6_stop_run",   16'(b_run),   16'd0);
        chk("m6_stop_digit", 16'(b_digit), 16'd1);
        b_stop = 1'b0;
        edge1();
        chk("m6_stop_frozen", 16'(b_digit), 16'd1);

        // Group C: 60-tick cascade
        c_tick = 1'b1;
        c_start = 1'b1;
        edge1();
        c_start = 1'b0;
        chk("cas_run", 16'({cu_run, ct_run}), 16'd3);
        u_exp = 0;
        t_exp = 0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            #1;
            chk("cas_u_carry", 16'(cu_carry), (u_exp == 9) ? 16'd1 : 16'd0);
            chk("cas_t_carry", 16'(ct_carry), (u_exp == 9 && t_exp == 5) ? 16'd1 : 16'd0);
            if (ct_carry) pulses++;
            edge1();
            if (u_exp == 9) begin
                u_exp = 0;
                t_exp = (t_exp + 1) % 6;
            end else begin
                u_exp = u_exp + 1;
            end
            chk("cas_units", 16'(cu_digit), 16'(u_exp));
            chk("cas_tens",  16'(ct_digit), 16'(t_exp));
        end
        chk("cas_end", 16'({ct_digit, cu_digit}), 16'h00);
        chk("cas_pulses", 16'(pulses), 16'd1);

        // Asynchronous reset mid-count
        repeat (3) edge1();
        chk("pre_rst_units", 16'(cu_digit), 16'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_digits", 16'({ct_digit, cu_digit}), 16'h00);
        chk("midrst_run",    16'({cu_run, ct_run}), 16'd0);
        chk("midrst_carry",  16'({cu_carry, ct_carry}), 16'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
